// File: rtl/display_decoder_pkg.sv
// Shared definitions for the seven-segment pair decoder: the active-low
// segment patterns for digits 0..9, the blank pattern, value limits and the
// FSM state encoding. Segment bit order is bit0=a .. bit6=g.
package display_decoder_pkg;

    localparam int SEG_W = 7;
    localparam int VAL_W = 5;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Largest value representable on the 5-bit result bus.
    localparam logic [6:0] MAX_VALUE = 7'd31;

    typedef enum logic [1:0] {
        ST_TENS = 2'd0,
        ST_ONES = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Two-digit value in 7-bit arithmetic (99 is the largest legal pair).
    function automatic logic [6:0] pair_value(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        logic [6:0] o7;
        t7 = {3'd0, tens};
        o7 = {3'd0, ones};
        return (t7 << 3) + (t7 << 1) + o7;
    endfunction

endpackage

// File: rtl/display_decoder_if.sv
// Handshake bundle between a digit producer / result consumer and the
// display decoder. The slave modport is the decoder's view; the master
// modport is the view of whatever feeds digits and drains results.
interface display_decoder_if;
    import display_decoder_pkg::*;

    logic [SEG_W-1:0] in_seg;
    logic             in_val;
    logic             in_rdy;
    logic [VAL_W-1:0] out;
    logic             out_err;
    logic             out_val;
    logic             out_rdy;

    modport master (
        output in_seg,
        output in_val,
        input  in_rdy,
        input  out,
        input  out_err,
        input  out_val,
        output out_rdy
    );

    modport slave (
        input  in_seg,
        input  in_val,
        output in_rdy,
        output out,
        output out_err,
        output out_val,
        input  out_rdy
    );

endinterface

// File: rtl/display_decoder_seg_to_digit.sv
// Combinational seven-segment to BCD lookup. Only the ten canonical digit
// patterns are legal; anything else reports legal=0 and digit 0 so that an
// illegal digit contributes nothing to downstream arithmetic.
module seg_to_digit
    import display_decoder_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [3:0]       o_digit,
    output logic             o_legal
);

    // Pattern lookup with an explicit illegal fallback.
    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: begin
                o_digit = 4'd0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// Seven-segment pair decoder: takes a tens digit then a ones digit and emits
// one registered 5-bit value per pair, flagging illegal patterns or values
// above 31. A single segment lookup is shared by both digit positions.
// Optional build macro: DISPLAY_DECODER_BLANK_EN -- accept the all-off
// pattern as a leading-zero tens digit.
module display_decoder
    import display_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    display_decoder_if.slave   bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_tens;
    logic [3:0]       w_tens_next;
    logic             r_err;
    logic             w_err_next;
    logic [VAL_W-1:0] r_out;
    logic [VAL_W-1:0] w_out_next;
    logic             r_out_err;
    logic             w_out_err_next;
    logic             r_out_val;
    logic             w_out_val_next;

    logic [3:0]       w_digit;
    logic             w_legal;
    logic             w_tens_legal;
    logic             w_ones_err;
    logic [6:0]       w_sum;
    logic             w_in_fire;
    logic             w_out_fire;

    seg_to_digit u_seg_to_digit (
        .i_seg   (bus.in_seg),
        .o_digit (w_digit),
        .o_legal (w_legal)
    );

`ifdef DISPLAY_DECODER_BLANK_EN
    // A blank leading digit is a legitimate zero in the tens position.
    assign w_tens_legal = w_legal | (bus.in_seg == SEG_BLANK);
`else
    assign w_tens_legal = w_legal;
`endif

    assign w_sum      = pair_value(r_tens, w_digit);
    assign w_ones_err = r_err | ~w_legal;
    assign w_in_fire  = bus.in_val & bus.in_rdy;
    assign w_out_fire = r_out_val & bus.out_rdy;

    assign bus.in_rdy  = (r_state != ST_OUT);
    assign bus.out     = r_out;
    assign bus.out_err = r_out_err;
    assign bus.out_val = r_out_val;

    // Next-state and next-result logic; everything holds unless a transfer happens.
    always_comb begin
        w_state_next   = r_state;
        w_tens_next    = r_tens;
        w_err_next     = r_err;
        w_out_next     = r_out;
        w_out_err_next = r_out_err;
        w_out_val_next = r_out_val;
        case (r_state)
            ST_TENS: begin
                if (w_in_fire) begin
                    w_tens_next  = w_digit;
                    w_err_next   = ~w_tens_legal;
                    w_state_next = ST_ONES;
                end else begin
                    w_state_next = ST_TENS;
                end
            end
            ST_ONES: begin
                // An illegal tens digit still consumes this slot as the ones digit.
                if (w_in_fire) begin
                    w_err_next     = w_ones_err;
                    w_out_err_next = w_ones_err | (w_sum > MAX_VALUE);
                    if (w_ones_err | (w_sum > MAX_VALUE)) begin
                        w_out_next = 5'd0;
                    end else begin
                        w_out_next = w_sum[VAL_W-1:0];
                    end
                    w_out_val_next = 1'b1;
                    w_state_next   = ST_OUT;
                end else begin
                    w_state_next = ST_ONES;
                end
            end
            ST_OUT: begin
                // Result is held until the consumer takes it.
                if (w_out_fire) begin
                    w_out_val_next = 1'b0;
                    w_err_next     = 1'b0;
                    w_tens_next    = 4'd0;
                    w_state_next   = ST_TENS;
                end else begin
                    w_state_next = ST_OUT;
                end
            end
            default: begin
                w_state_next   = ST_TENS;
                w_tens_next    = 4'd0;
                w_err_next     = 1'b0;
                w_out_next     = 5'd0;
                w_out_err_next = 1'b0;
                w_out_val_next = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset that drops any partial pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_TENS;
            r_tens    <= 4'd0;
            r_err     <= 1'b0;
            r_out     <= 5'd0;
            r_out_err <= 1'b0;
            r_out_val <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tens    <= w_tens_next;
            r_err     <= w_err_next;
            r_out     <= w_out_next;
            r_out_err <= w_out_err_next;
            r_out_val <= w_out_val_next;
        end
    end

endmodule

// File: doc/display_decoder.md
DISPLAY_DECODER -- requirements
Module: display_decoder

Interface
REQ-001 Single clock and single reset SHALL be used; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_seg  input  7  one seven-segment digit pattern, active-low, bit0=a .. bit6=g.
REQ-005 in_val  input  1  in_seg valid this cycle.
REQ-006 in_rdy  output  1  block accepts in_seg this cycle; transfer when in_val && in_rdy.
REQ-007 out  output  5  decoded binary value 0..31.
REQ-008 out_err  output  1  result invalid (bad pattern or value > 31); meaningful only while out_val=1.
REQ-009 out_val  output  1  out/out_err valid.
REQ-010 out_rdy  input  1  consumer accepts result; transfer when out_val && out_rdy.

Function
REQ-011 Digits SHALL arrive as pairs: tens first, then ones; one result per pair.
REQ-012 Legal patterns (in_seg, binary) SHALL be exactly: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other pattern is illegal.
REQ-013 FSM states SHALL be TENS, ONES, OUT; reset state TENS.
REQ-014 TENS: in_rdy=1; on transfer, register tens digit and a sticky error bit (set if illegal), go to ONES.
REQ-015 ONES: in_rdy=1; on transfer, compute tens*10+ones in 7-bit arithmetic, set error if ones illegal, go to OUT.
REQ-016 An illegal tens digit SHALL NOT break pair framing; the next digit is still taken as ones.
REQ-017 OUT: in_rdy=0, out_val=1; out_err=1 if sticky error set or sum > 31.
REQ-018 out SHALL equal sum[4:0] when out_err=0, and 5'd0 when out_err=1.
REQ-019 out, out_err SHALL be held stable while out_val=1 and out_rdy=0.
REQ-020 On out transfer, return to TENS next cycle and clear sticky error; no input accepted in the transfer cycle.
REQ-021 Latency: out_val SHALL assert the cycle after the ones transfer; min throughput one result per 3 cycles.
REQ-022 in_val without transfer (state OUT) SHALL leave state unchanged.
REQ-023 out, out_err SHALL be driven from registers, no combinational path from in_seg to out.

Reset
REQ-024 On rst: state=TENS, out=0, out_err=0, out_val=0, sticky error=0, stored tens=0; in_rdy=1 the cycle after reset deasserts.
REQ-025 rst asserted mid-pair or in OUT SHALL discard the partial/pending result without emitting it.

Configuration
REQ-026 Macro DISPLAY_DECODER_BLANK_EN: when defined, pattern 1111111 (all off) SHALL be legal as tens digit only, decoding to 0; as ones digit it stays illegal.
REQ-027 Without DISPLAY_DECODER_BLANK_EN, 1111111 SHALL be illegal in both positions.

Structure
REQ-028 Shared package SHALL hold the ten digit pattern constants, the blank pattern, and the FSM state encoding.
REQ-029 One combinational sub-module seg_to_digit SHALL map in_seg to a 4-bit digit plus a legal flag; instantiated once and shared by both states.

Verification
REQ-030 Pair 0100100 (2), 0010010 (5), out_rdy=1 -> out_val next cycle after ones, out=25, out_err=0.
REQ-031 Pair 0110000 (3), 0100100 (2) -> out=0, out_err=1 (32 > 31); pair 3,1 -> out=31, out_err=0.
REQ-032 Tens 0000001 (illegal), ones 1111001 -> one result, out=0, out_err=1; next pair 1,0 -> out=10, out_err=0.
REQ-033 out_rdy=0 for 5 cycles after result 17 -> out/out_val stable, in_rdy=0 throughout; release -> TENS, in_rdy=1 next cycle.
REQ-034 rst pulsed after tens digit 2 accepted -> no output; next pair 0,7 -> out=7.
REQ-035 Tens 1111111, ones 1111001 -> with DISPLAY_DECODER_BLANK_EN out=1, out_err=0; without it out=0, out_err=1.
